axis_xfer_sequencer: RTL and testbench

- Command-driven controller that sequences the AXI-Stream BRAM transfer datapath (axis top / top_level_dummy) by driving instruction_code and the wr_*/rd_* window registers.
- Accepts one transfer command at a time and holds the matching instruction for the whole transfer.
- Counts the datapath's stream beats and detects completion, early/late TLAST and timeout.
- Returns instruction_code to idle (8'h00) for a guard gap between commands.

---
 rtl/xfer_pkg.sv | 21 ++
 rtl/xfer_beat_monitor.sv | 52 +++++
 rtl/axis_xfer_sequencer.sv | 167 ++++++++++++++++
 tb/tb_axis_xfer_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xfer_pkg.sv
// Shared definitions for the AXI-Stream BRAM transfer sequencer: opcodes,
// FSM state encoding and error-bit positions.
package xfer_pkg;

  localparam logic [7:0] OP_IDLE  = 8'h00;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_ACTIVE,
    ST_DRAIN,
    ST_GAP
  } xfer_state_t;

  localparam int unsigned ERR_CFG     = 0;
  localparam int unsigned ERR_LAST    = 1;
  localparam int unsigned ERR_TIMEOUT = 2;

endpackage

// File: rtl/xfer_beat_monitor.sv
// Beat counter, last-vs-count comparison and idle-beat timeout for the
// transfer currently in its ACTIVE phase.
module xfer_beat_monitor #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        clear,
  input  logic        active,
  input  logic        beat,
  input  logic        last,
  input  logic [15:0] count,
  output logic [15:0] beat_count,
  output logic        complete,
  output logic        mismatch,
  output logic        timeout
);

  logic [31:0] idle_cnt;
  logic [16:0] next_cnt;
  logic [16:0] count_ext;
  logic        at_end;

  always_comb begin
    next_cnt  = {1'b0, beat_count} + 17'd1;
    count_ext = {1'b0, count};
    at_end    = (next_cnt == count_ext);
    complete  = active && beat && last && at_end;
    mismatch  = active && beat && ((last && (next_cnt < count_ext)) || (!last && at_end));
    timeout   = active && !beat && (idle_cnt == TIMEOUT_CYCLES - 1);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      beat_count <= '0;
      idle_cnt   <= '0;
    end else begin
      if (clear) begin
        beat_count <= '0;
      end else if (active && beat && (beat_count != '1)) begin
        beat_count <= beat_count + 16'd1;
      end
      // Idle-cycle counter restarts on every counted beat and outside ACTIVE.
      if (!active || beat) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/axis_xfer_sequencer.sv
// Command-driven sequencer for the AXI-Stream BRAM datapath: latches the
// transfer window, drives instruction_code and supervises beat completion.
module axis_xfer_sequencer
  import xfer_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 5,
  parameter int unsigned DRAIN_CYCLES   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [4:0]  cmd_bram_start,
  input  logic [4:0]  cmd_bram_end,
  input  logic [15:0] cmd_addr_start,
  input  logic [15:0] cmd_addr_count,
  input  logic        s_beat,
  input  logic        s_last,
  input  logic        m_beat,
  input  logic        m_last,
  output logic [7:0]  instruction_code,
  output logic [4:0]  wr_bram_start,
  output logic [4:0]  wr_bram_end,
  output logic [15:0] wr_addr_start,
  output logic [15:0] wr_addr_count,
  output logic [3:0]  rd_bram_start,
  output logic [3:0]  rd_bram_end,
  output logic [15:0] rd_addr_start,
  output logic [15:0] rd_addr_count,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err,
  output logic [15:0] beat_count
);

  xfer_state_t state, state_nxt;
  logic        op_q;
  logic [15:0] count_q;
  logic [31:0] phase_cnt;
  logic        cfg_bad, accept, reject;
  logic        beat_sel, last_sel;
  logic        complete, mismatch, timeout;
  logic        drain_end, gap_end;

  assign beat_sel = op_q ? m_beat : s_beat;
  assign last_sel = op_q ? m_last : s_last;

  xfer_beat_monitor #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_mon (
    .aclk       (aclk),
    .areset     (areset),
    .clear      (accept),
    .active     (state == ST_ACTIVE),
    .beat       (beat_sel),
    .last       (last_sel),
    .count      (count_q),
    .beat_count (beat_count),
    .complete   (complete),
    .mismatch   (mismatch),
    .timeout    (timeout)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    cfg_bad          = (cmd_addr_count == '0) || (cmd_bram_end < cmd_bram_start) ||
                       (cmd_op && (cmd_bram_end > 5'd15));
    accept           = 1'b0;
    reject           = 1'b0;
    drain_end        = (phase_cnt == DRAIN_CYCLES - 1);
    gap_end          = (phase_cnt == GAP_CYCLES - 1);
    state_nxt        = state;
    cmd_ready        = 1'b0;
    busy             = 1'b1;
    done             = 1'b0;
    instruction_code = OP_IDLE;
    unique case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          accept    = !cfg_bad;
          reject    = cfg_bad;
          state_nxt = cfg_bad ? ST_GAP : ST_ARM;
        end
      end
      ST_ARM:    state_nxt = ST_ACTIVE;
      ST_ACTIVE: begin
        instruction_code = op_q ? OP_READ : OP_WRITE;
        if (timeout)                    state_nxt = ST_GAP;
        else if (complete || mismatch)  state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        instruction_code = op_q ? OP_READ : OP_WRITE;
        if (drain_end) state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (gap_end) begin
          done      = (err == '0);
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      phase_cnt <= '0;
    end else if ((state_nxt != state) || !((state == ST_DRAIN) || (state == ST_GAP))) begin
      phase_cnt <= '0;
    end else begin
      phase_cnt <= phase_cnt + 32'd1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      op_q          <= 1'b0;
      count_q       <= '0;
      wr_bram_start <= '0;
      wr_bram_end   <= '0;
      wr_addr_start <= '0;
      wr_addr_count <= '0;
      rd_bram_start <= '0;
      rd_bram_end   <= '0;
      rd_addr_start <= '0;
      rd_addr_count <= '0;
    end else if (accept) begin
      op_q    <= cmd_op;
      count_q <= cmd_addr_count;
      if (cmd_op) begin
        rd_bram_start <= cmd_bram_start[3:0];
        rd_bram_end   <= cmd_bram_end[3:0];
        rd_addr_start <= cmd_addr_start;
        rd_addr_count <= cmd_addr_count;
      end else begin
        wr_bram_start <= cmd_bram_start;
        wr_bram_end   <= cmd_bram_end;
        wr_addr_start <= cmd_addr_start;
        wr_addr_count <= cmd_addr_count;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      err <= '0;
    end else if (accept) begin
      err <= '0;
    end else if (reject) begin
      err           <= '0;
      err[ERR_CFG]  <= 1'b1;
    end else begin
      // Any beat during DRAIN means the stream overran the programmed count.
      if (((state == ST_ACTIVE) && mismatch) || ((state == ST_DRAIN) && beat_sel))
        err[ERR_LAST] <= 1'b1;
      if (timeout)
        err[ERR_TIMEOUT] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_xfer_sequencer.sv
// Directed self-checking bench for axis_xfer_sequencer (timeout reduced to 20).
module tb_axis_xfer_sequencer;

  logic        aclk, areset;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [4:0]  cmd_bram_start, cmd_bram_end;
  logic [15:0] cmd_addr_start, cmd_addr_count;
  logic        s_beat, s_last, m_beat, m_last;
  logic [7:0]  instruction_code;
  logic [4:0]  wr_bram_start, wr_bram_end;
  logic [15:0] wr_addr_start, wr_addr_count;
  logic [3:0]  rd_bram_start, rd_bram_end;
  logic [15:0] rd_addr_start, rd_addr_count;
  logic        busy, done;
  logic [2:0]  err;
  logic [15:0] beat_count;

  int unsigned passed = 0;
  int unsigned total  = 0;

  axis_xfer_sequencer #(
    .GAP_CYCLES     (5),
    .DRAIN_CYCLES   (16),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .aclk             (aclk),
    .areset           (areset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_bram_start   (cmd_bram_start),
    .cmd_bram_end     (cmd_bram_end),
    .cmd_addr_start   (cmd_addr_start),
    .cmd_addr_count   (cmd_addr_count),
    .s_beat           (s_beat),
    .s_last           (s_last),
    .m_beat           (m_beat),
    .m_last           (m_last),
    .instruction_code (instruction_code),
    .wr_bram_start    (wr_bram_start),
    .wr_bram_end      (wr_bram_end),
    .wr_addr_start    (wr_addr_start),
    .wr_addr_count    (wr_addr_count),
    .rd_bram_start    (rd_bram_start),
    .rd_bram_end      (rd_bram_end),
    .rd_addr_start    (rd_addr_start),
    .rd_addr_count    (rd_addr_count),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .beat_count       (beat_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  // Presents a command for one cycle from IDLE; returns one cycle later.
  task automatic send_cmd(input string tag, input logic op, input logic [4:0] bs,
                          input logic [4:0] be, input logic [15:0] as, input logic [15:0] cnt);
    chk({tag, "_ready_pre"}, cmd_ready, 1);
    cmd_op         = op;
    cmd_bram_start = bs;
    cmd_bram_end   = be;
    cmd_addr_start = as;
    cmd_addr_count = cnt;
    cmd_valid      = 1'b1;
    step();
    cmd_valid      = 1'b0;
  endtask

  // Drives n counted beats on the selected side; the other side carries
  // beat+last noise that must be ignored.
  task automatic run_beats(input logic op, input int unsigned n, input int unsigned last_at);
    for (int unsigned i = 1; i <= n; i++) begin
      if (op) begin
        m_beat = 1'b1; m_last = (i == last_at);
        s_beat = 1'b1; s_last = 1'b1;
      end else begin
        s_beat = 1'b1; s_last = (i == last_at);
        m_beat = 1'b1; m_last = 1'b1;
      end
      step();
    end
    s_beat = 1'b0; s_last = 1'b0;
    m_beat = 1'b0; m_last = 1'b0;
  endtask

  // Entered at the first DRAIN cycle: 16 cycles of opcode, then 5 of GAP.
  task automatic drain_gap(input string tag, input logic [7:0] code, input logic exp_done);
    steps(15);
    chk({tag, "_drain_code"}, instruction_code, code);
    chk({tag, "_drain_nodone"}, done, 0);
    step();
    chk({tag, "_gap_code"}, instruction_code, 8'h00);
    chk({tag, "_gap_ready"}, cmd_ready, 0);
    chk({tag, "_gap_busy"}, busy, 1);
    steps(4);
    chk({tag, "_gap_end_done"}, done, exp_done);
    chk({tag, "_gap_end_ready"}, cmd_ready, 0);
    step();
    chk({tag, "_idle_ready"}, cmd_ready, 1);
    chk({tag, "_idle_done"}, done, 0);
  endtask

  task automatic reject_case(input string tag, input logic op, input logic [4:0] bs,
                             input logic [4:0] be, input logic [15:0] cnt);
    send_cmd(tag, op, bs, be, 16'h0000, cnt);
    chk({tag, "_err"}, err, 3'b001);
    chk({tag, "_code"}, instruction_code, 8'h00);
    chk({tag, "_ready"}, cmd_ready, 0);
    chk({tag, "_wr_kept"}, wr_addr_count, 4);
    chk({tag, "_rd_kept"}, rd_addr_count, 512);
    steps(4);
    chk({tag, "_ready_end"}, cmd_ready, 0);
    chk({tag, "_nodone"}, done, 0);
    chk({tag, "_code_end"}, instruction_code, 8'h00);
    step();
    chk({tag, "_ready_back"}, cmd_ready, 1);
  endtask

  initial begin
    areset = 1'b1;
    cmd_valid = 1'b0; cmd_op = 1'b0;
    cmd_bram_start = '0; cmd_bram_end = '0; cmd_addr_start = '0; cmd_addr_count = '0;
    s_beat = 1'b0; s_last = 1'b0; m_beat = 1'b0; m_last = 1'b0;
    #2;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_code", instruction_code, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_beats", beat_count, 0);
    chk("rst_wr_cnt", wr_addr_count, 0);
    @(negedge aclk);
    areset = 1'b0;
    step();

    // Write 512 beats into bram 0..3.
    send_cmd("w512", 1'b0, 5'd0, 5'd3, 16'h0000, 16'd512);
    chk("w512_arm_code", instruction_code, 8'h00);
    chk("w512_arm_busy", busy, 1);
    chk("w512_wr_bs", wr_bram_start, 0);
    chk("w512_wr_be", wr_bram_end, 3);
    chk("w512_wr_as", wr_addr_start, 0);
    chk("w512_wr_cnt", wr_addr_count, 512);
    step();
    chk("w512_active_code", instruction_code, 8'h01);
    run_beats(1'b0, 512, 512);
    chk("w512_beats", beat_count, 512);
    chk("w512_err", err, 0);
    chk("w512_drain_code0", instruction_code, 8'h01);
    drain_gap("w512", 8'h01, 1'b1);
    chk("w512_err_end", err, 0);

    // Read 512 beats from bram 0..3.
    send_cmd("r512", 1'b1, 5'd0, 5'd3, 16'h0000, 16'd512);
    chk("r512_rd_bs", rd_bram_start, 0);
    chk("r512_rd_be", rd_bram_end, 3);
    chk("r512_rd_as", rd_addr_start, 0);
    chk("r512_rd_cnt", rd_addr_count, 512);
    chk("r512_wr_kept", wr_addr_count, 512);
    step();
    chk("r512_active_code", instruction_code, 8'h02);
    run_beats(1'b1, 512, 512);
    chk("r512_beats", beat_count, 512);
    chk("r512_err", err, 0);
    drain_gap("r512", 8'h02, 1'b1);

    // Write count 8 with TLAST on beat 5.
    send_cmd("early", 1'b0, 5'd1, 5'd2, 16'h0040, 16'd8);
    chk("early_wr_bs", wr_bram_start, 1);
    chk("early_wr_as", wr_addr_start, 16'h40);
    chk("early_wr_cnt", wr_addr_count, 8);
    chk("early_rd_kept", rd_bram_end, 3);
    step();
    run_beats(1'b0, 5, 5);
    chk("early_err", err, 3'b010);
    chk("early_beats", beat_count, 5);
    chk("early_drain_code", instruction_code, 8'h01);
    drain_gap("early", 8'h01, 1'b0);
    chk("early_err_sticky", err, 3'b010);

    // Write count 4, no beats: timeout after 20 idle cycles.
    send_cmd("tmo", 1'b0, 5'd0, 5'd3, 16'h0000, 16'd4);
    chk("tmo_err_cleared", err, 0);
    chk("tmo_beats_cleared", beat_count, 0);
    step();
    steps(19);
    chk("tmo_last_active_code", instruction_code, 8'h01);
    chk("tmo_last_active_err", err, 0);
    step();
    chk("tmo_code", instruction_code, 8'h00);
    chk("tmo_err", err, 3'b100);
    chk("tmo_ready", cmd_ready, 0);
    steps(4);
    chk("tmo_nodone", done, 0);
    step();
    chk("tmo_ready_back", cmd_ready, 1);

    // Configuration rejects.
    reject_case("rej_cnt0", 1'b0, 5'd0, 5'd3, 16'd0);
    reject_case("rej_order", 1'b0, 5'd3, 5'd2, 16'd4);
    reject_case("rej_rdend", 1'b1, 5'd0, 5'd20, 16'd4);

    // Asynchronous reset mid-transfer, then a normal read at bram_end=15.
    send_cmd("arst", 1'b0, 5'd0, 5'd3, 16'h0020, 16'd512);
    step();
    run_beats(1'b0, 100, 0);
    chk("arst_beats_pre", beat_count, 100);
    chk("arst_code_pre", instruction_code, 8'h01);
    areset = 1'b1;
    #1;
    chk("arst_code", instruction_code, 8'h00);
    chk("arst_busy", busy, 0);
    chk("arst_ready", cmd_ready, 1);
    chk("arst_beats", beat_count, 0);
    chk("arst_wr_cnt", wr_addr_count, 0);
    chk("arst_rd_cnt", rd_addr_count, 0);
    #1;
    areset = 1'b0;
    step();
    send_cmd("post", 1'b1, 5'd2, 5'd15, 16'h0010, 16'd3);
    chk("post_rd_bs", rd_bram_start, 2);
    chk("post_rd_be", rd_bram_end, 15);
    chk("post_rd_as", rd_addr_start, 16'h10);
    chk("post_rd_cnt", rd_addr_count, 3);
    chk("post_wr_cnt", wr_addr_count, 0);
    step();
    chk("post_code", instruction_code, 8'h02);
    run_beats(1'b1, 3, 3);
    chk("post_beats", beat_count, 3);
    chk("post_err", err, 0);
    drain_gap("post", 8'h02, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
